// File: rtl/if_pc_fetch.sv
// if_pc_fetch: PC generator and fetch-request source for the IF stage.
//
// Issues one aligned packet of up to FETCH_WIDTH instructions per
// fetch_valid & fetch_ready handshake. Redirects on flush (exception/eret)
// and on taken branches. Honours the MIPS branch delay slot by truncating
// the delay-slot packet and redirecting after it has been issued.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_ready     downstream accepts the current packet
//   flush_valid     redirect to flush_target (highest priority after rst)
//   flush_target    flush redirect address
//   branch_valid    one-cycle pulse: a taken branch resolved
//   branch_pc       PC of the branch instruction
//   branch_target   branch destination
//   fetch_valid     packet valid
//   fetch_pc        PC of the first valid lane
//   fetch_mask      per-lane valid bits; lane i holds base + 4*i
//   fetch_adel      fetch_pc is not word aligned
//   branch_pending  branch latched, waiting for its delay slot to issue
module if_pc_fetch #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FETCH_WIDTH  = 1,
  parameter logic [31:0] RESET_VECTOR = 32'hbfc0_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_ready,
  input  logic                   flush_valid,
  input  logic [ADDR_W-1:0]      flush_target,
  input  logic                   branch_valid,
  input  logic [ADDR_W-1:0]      branch_pc,
  input  logic [ADDR_W-1:0]      branch_target,
  output logic                   fetch_valid,
  output logic [ADDR_W-1:0]      fetch_pc,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic                   fetch_adel,
  output logic                   branch_pending
);

  localparam int unsigned PktBytes = 4 * FETCH_WIDTH;
  // Lane index needs at least one bit even when there is a single lane.
  localparam int unsigned LaneW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(PktBytes - 1));
  localparam logic [ADDR_W-1:0] PktStep   = ADDR_W'(PktBytes);
  localparam logic [LaneW-1:0]  LaneMask  = LaneW'(FETCH_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ResetPc   = ADDR_W'(RESET_VECTOR);

  typedef enum logic {StSeq, StWaitDs} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [ADDR_W-1:0]   ds_q, ds_d;

  logic [ADDR_W-1:0]   base, ds_base, ds_dist;
  logic [LaneW-1:0]    start, ds_lane;
  logic                in_wait, ds_equal, ds_behind, handshake;

  function automatic logic [LaneW-1:0] lane_of(input logic [ADDR_W-1:0] a);
    return LaneW'(a >> 2) & LaneMask;
  endfunction

  // Delay-slot position relative to the current packet. The distance is
  // taken modulo 2^ADDR_W, so a wrapped address is still "ahead" when it is
  // fewer than half the address space away.
  always_comb begin
    base      = pc_q & AlignMask;
    ds_base   = ds_q & AlignMask;
    start     = lane_of(pc_q);
    ds_lane   = lane_of(ds_q);
    ds_dist   = ds_base - base;
    in_wait   = (state_q == StWaitDs);
    ds_equal  = (ds_dist == '0);
    ds_behind = ds_dist[ADDR_W-1];
  end

  always_comb begin
    fetch_pc       = pc_q;
    fetch_adel     = |pc_q[1:0];
    branch_pending = in_wait;
    fetch_valid    = valid_q & ~flush_valid & ~(in_wait & ds_behind);
    fetch_mask     = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      // A misaligned PC only exposes its own lane so the bad fetch is reported once.
      if (fetch_adel) begin
        fetch_mask[i] = (i == int'(start));
      end else begin
        fetch_mask[i] = (i >= int'(start));
      end
      // Nothing past the delay slot leaves on the sequential path.
      if (in_wait && ds_equal && (i > int'(ds_lane))) begin
        fetch_mask[i] = 1'b0;
      end
    end
  end

  assign handshake = fetch_valid & fetch_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = 1'b1;
    tgt_d   = tgt_q;
    ds_d    = ds_q;

    if (flush_valid) begin
      pc_d    = flush_target;
      state_d = StSeq;
    end else begin
      unique case (state_q)
        StSeq: begin
          if (handshake && !fetch_adel) begin
            pc_d = base + PktStep;
          end
          if (branch_valid) begin
            tgt_d   = branch_target;
            ds_d    = branch_pc + ADDR_W'(4);
            state_d = StWaitDs;
          end
        end
        StWaitDs: begin
          // A branch in the delay slot is not supported; branch_valid is ignored here.
          if (ds_behind) begin
            pc_d    = tgt_q;
            state_d = StSeq;
          end else if (ds_equal) begin
            if (handshake) begin
              pc_d    = tgt_q;
              state_d = StSeq;
            end
          end else if (handshake && !fetch_adel) begin
            pc_d = base + PktStep;
          end
        end
        default: state_d = StSeq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSeq;
      pc_q    <= ResetPc;
      valid_q <= 1'b0;
      tgt_q   <= '0;
      ds_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      tgt_q   <= tgt_d;
      ds_q    <= ds_d;
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: three instances (FETCH_WIDTH 1, 2, 4) share clock
// and reset; each scenario drives one instance while the others idle.
// Expected outputs are pushed to a scoreboard queue as stimulus is driven and
// compared against the DUT on the falling edge.
module tb_if_pc_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance inputs, index 0: W=1, 1: W=2, 2: W=4.
  logic        rdy [3];
  logic        fl  [3];
  logic [31:0] ft  [3];
  logic        bv  [3];
  logic [31:0] bpc [3];
  logic [31:0] btg [3];

  logic        fv0, fv1, fv2;
  logic [31:0] pc0, pc1, pc2;
  logic [0:0]  m0;
  logic [1:0]  m1;
  logic [3:0]  m2;
  logic        ad0, ad1, ad2;
  logic        bp0, bp1, bp2;

  if_pc_fetch #(.ADDR_W(32), .FETCH_WIDTH(1), .RESET_VECTOR(32'hbfc0_0000)) u_w1 (
    .clk(clk), .rst(rst), .fetch_ready(rdy[0]), .flush_valid(fl[0]),
    .flush_target(ft[0]), .branch_valid(bv[0]), .branch_pc(bpc[0]),
    .branch_target(btg[0]), .fetch_valid(fv0), .fetch_pc(pc0), .fetch_mask(m0),
    .fetch_adel(ad0), .branch_pending(bp0)
  );
  if_pc_fetch #(.ADDR_W(32), .FETCH_WIDTH(2), .RESET_VECTOR(32'hbfc0_0000)) u_w2 (
    .clk(clk), .rst(rst), .fetch_ready(rdy[1]), .flush_valid(fl[1]),
    .flush_target(ft[1]), .branch_valid(bv[1]), .branch_pc(bpc[1]),
    .branch_target(btg[1]), .fetch_valid(fv1), .fetch_pc(pc1), .fetch_mask(m1),
    .fetch_adel(ad1), .branch_pending(bp1)
  );
  if_pc_fetch #(.ADDR_W(32), .FETCH_WIDTH(4), .RESET_VECTOR(32'hbfc0_0000)) u_w4 (
    .clk(clk), .rst(rst), .fetch_ready(rdy[2]), .flush_valid(fl[2]),
    .flush_target(ft[2]), .branch_valid(bv[2]), .branch_pc(bpc[2]),
    .branch_target(btg[2]), .fetch_valid(fv2), .fetch_pc(pc2), .fetch_mask(m2),
    .fetch_adel(ad2), .branch_pending(bp2)
  );

  typedef struct {
    string       tag;
    int          d;
    logic        v;
    logic [31:0] pc;
    logic [3:0]  mask;
    logic        adel;
    logic        bp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input int d, input logic v, input logic [31:0] pc,
                      input logic [3:0] mask, input logic adel, input logic bp);
    exp_t e;
    e.tag = tag; e.d = d; e.v = v; e.pc = pc; e.mask = mask; e.adel = adel; e.bp = bp;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t e;
    logic        v, adel, bp;
    logic [31:0] pc;
    logic [3:0]  mask;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.d)
        0:       begin v = fv0; pc = pc0; mask = {3'b0, m0}; adel = ad0; bp = bp0; end
        1:       begin v = fv1; pc = pc1; mask = {2'b0, m1}; adel = ad1; bp = bp1; end
        default: begin v = fv2; pc = pc2; mask = m2;         adel = ad2; bp = bp2; end
      endcase
      cmp(e.tag, "valid", {31'b0, v}, {31'b0, e.v});
      cmp(e.tag, "pc", pc, e.pc);
      cmp(e.tag, "mask", {28'b0, mask}, {28'b0, e.mask});
      cmp(e.tag, "adel", {31'b0, adel}, {31'b0, e.adel});
      cmp(e.tag, "pending", {31'b0, bp}, {31'b0, e.bp});
    end
  endtask

  // Compare on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = 1'b0; fl[i] = 1'b0; ft[i] = '0; bv[i] = 1'b0; bpc[i] = '0; btg[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset values on all widths, two reset cycles.
    push("rst_w1", 0, 1'b0, 32'hbfc0_0000, 4'b0001, 1'b0, 1'b0);
    push("rst_w2", 1, 1'b0, 32'hbfc0_0000, 4'b0011, 1'b0, 1'b0);
    push("rst_w4", 2, 1'b0, 32'hbfc0_0000, 4'b1111, 1'b0, 1'b0);
    tick();
    push("rst2_w2", 1, 1'b0, 32'hbfc0_0000, 4'b0011, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    push("post_rst_idle", 1, 1'b0, 32'hbfc0_0000, 4'b0011, 1'b0, 1'b0);
    tick();
    rdy[1] = 1'b1;
    push("post_rst_pkt0", 1, 1'b1, 32'hbfc0_0000, 4'b0011, 1'b0, 1'b0);
    tick();
    push("post_rst_pkt1", 1, 1'b1, 32'hbfc0_0008, 4'b0011, 1'b0, 1'b0);
    tick();
    rdy[1] = 1'b0;                               // W=2 now parked at bfc0_0010

    // Stall, W=1 at 0x100.
    fl[0] = 1'b1; ft[0] = 32'h100;
    push("stall_flush", 0, 1'b0, 32'hbfc0_0000, 4'b0001, 1'b0, 1'b0);
    tick();
    fl[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 0, 1'b1, 32'h100, 4'b0001, 1'b0, 1'b0);
      tick();
    end
    rdy[0] = 1'b1;
    push("stall_release", 0, 1'b1, 32'h100, 4'b0001, 1'b0, 1'b0);
    tick();
    rdy[0] = 1'b0;
    push("stall_next", 0, 1'b1, 32'h104, 4'b0001, 1'b0, 1'b0);
    tick();

    // Branch delay slot, W=2: branch at 0x1004, target 0x2004.
    fl[1] = 1'b1; ft[1] = 32'h1000;
    push("ds_flush", 1, 1'b0, 32'hbfc0_0010, 4'b0011, 1'b0, 1'b0);
    tick();
    fl[1] = 1'b0; rdy[1] = 1'b1;
    bv[1] = 1'b1; bpc[1] = 32'h1004; btg[1] = 32'h2004;
    push("ds_branch_pkt", 1, 1'b1, 32'h1000, 4'b0011, 1'b0, 1'b0);
    tick();
    bv[1] = 1'b0;
    push("ds_slot_pkt", 1, 1'b1, 32'h1008, 4'b0001, 1'b0, 1'b1);
    tick();
    push("ds_target_pkt", 1, 1'b1, 32'h2004, 4'b0010, 1'b0, 1'b0);
    tick();
    rdy[1] = 1'b0;

    // Delay slot already issued, W=1: branch at 0x100 while fetching 0x10c.
    fl[0] = 1'b1; ft[0] = 32'h10c;
    push("dsi_flush", 0, 1'b0, 32'h104, 4'b0001, 1'b0, 1'b0);
    tick();
    fl[0] = 1'b0; rdy[0] = 1'b1;
    bv[0] = 1'b1; bpc[0] = 32'h100; btg[0] = 32'h3000;
    push("dsi_branch_pkt", 0, 1'b1, 32'h10c, 4'b0001, 1'b0, 1'b0);
    tick();
    bv[0] = 1'b0;
    push("dsi_bubble", 0, 1'b0, 32'h110, 4'b0001, 1'b0, 1'b1);
    tick();
    push("dsi_target", 0, 1'b1, 32'h3000, 4'b0001, 1'b0, 1'b0);
    tick();
    rdy[0] = 1'b0;                               // W=1 parked at 0x3004

    // Flush and branch in the same cycle, W=4.
    fl[2] = 1'b1; ft[2] = 32'hbfc0_0380;
    bv[2] = 1'b1; bpc[2] = 32'h500; btg[2] = 32'h600;
    push("fvb_same_cycle", 2, 1'b0, 32'hbfc0_0000, 4'b1111, 1'b0, 1'b0);
    tick();
    fl[2] = 1'b0; bv[2] = 1'b0;
    push("fvb_target", 2, 1'b1, 32'hbfc0_0380, 4'b1111, 1'b0, 1'b0);
    tick();

    // Wraparound, W=4.
    fl[2] = 1'b1; ft[2] = 32'hffff_fff0;
    push("wrap_flush", 2, 1'b0, 32'hbfc0_0380, 4'b1111, 1'b0, 1'b0);
    tick();
    fl[2] = 1'b0; rdy[2] = 1'b1;
    push("wrap_top", 2, 1'b1, 32'hffff_fff0, 4'b1111, 1'b0, 1'b0);
    tick();
    rdy[2] = 1'b0;
    push("wrap_zero", 2, 1'b1, 32'h0000_0000, 4'b1111, 1'b0, 1'b0);
    tick();

    // Mid-packet target, W=4: partial mask.
    fl[2] = 1'b1; ft[2] = 32'h2008;
    push("mid_flush", 2, 1'b0, 32'h0000_0000, 4'b1111, 1'b0, 1'b0);
    tick();
    fl[2] = 1'b0;
    push("mid_partial", 2, 1'b1, 32'h2008, 4'b1100, 1'b0, 1'b0);
    tick();

    // Misaligned target, W=4: only the start lane.
    fl[2] = 1'b1; ft[2] = 32'h2006;
    push("adel4_flush", 2, 1'b0, 32'h2008, 4'b1100, 1'b0, 1'b0);
    tick();
    fl[2] = 1'b0;
    push("adel4_lane", 2, 1'b1, 32'h2006, 4'b0010, 1'b1, 1'b0);
    tick();

    // Misaligned target, W=1: stalls under handshake until the next flush.
    fl[0] = 1'b1; ft[0] = 32'h2002;
    push("adel_flush", 0, 1'b0, 32'h3004, 4'b0001, 1'b0, 1'b0);
    tick();
    fl[0] = 1'b0; rdy[0] = 1'b1;
    push("adel_set", 0, 1'b1, 32'h2002, 4'b0001, 1'b1, 1'b0);
    tick();
    push("adel_hold", 0, 1'b1, 32'h2002, 4'b0001, 1'b1, 1'b0);
    tick();
    fl[0] = 1'b1; ft[0] = 32'h200;
    push("adel_reflush", 0, 1'b0, 32'h2002, 4'b0001, 1'b1, 1'b0);
    tick();
    fl[0] = 1'b0; rdy[0] = 1'b0;
    push("adel_clear", 0, 1'b1, 32'h200, 4'b0001, 1'b0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
